// File: rtl/esn7e_demo_led_pkg.sv
// Shared constants for the LED output-port controller: register map,
// STATUS bit positions and the default blink half-period.
package esn7e_demo_led_pkg;

    localparam logic [2:0] ADDR_DATA       = 3'd0;
    localparam logic [2:0] ADDR_BLINK_MASK = 3'd1;
    localparam logic [2:0] ADDR_OUTSET     = 3'd2;
    localparam logic [2:0] ADDR_OUTCLEAR   = 3'd3;
    localparam logic [2:0] ADDR_PERIOD     = 3'd4;
    localparam logic [2:0] ADDR_STATUS     = 3'd5;

    localparam int STATUS_PHASE_BIT = 0;
    localparam int STATUS_RUN_BIT   = 1;

    // 2499999 + 1 cycles = 50 ms half-period at 50 MHz
    localparam int unsigned DEF_PERIOD_RESET = 2499999;

endpackage

// File: rtl/esn7e_demo_led_blink_timer.sv
// Blink half-period timer: a down-counter that reloads from `period` and
// toggles `phase` every period+1 cycles while `run` is high. Idle or a
// restart parks the counter at `period` with phase 0.
module esn7e_demo_led_blink_timer
    import esn7e_demo_led_pkg::*;
#(
    parameter int unsigned PERIOD_W     = 24,
    parameter int unsigned PERIOD_RESET = DEF_PERIOD_RESET
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic                restart,
    input  logic [PERIOD_W-1:0] period,
    output logic                phase
);

    logic [PERIOD_W-1:0] count_q, count_d;
    logic                phase_q, phase_d;

    // Restart/idle win over the terminal-count reload so a new PERIOD
    // always yields a full first half-period.
    always_comb begin
        count_d = count_q;
        phase_d = phase_q;
        if (restart || !run) begin
            count_d = period;
            phase_d = 1'b0;
        end else if (count_q == '0) begin
            count_d = period;
            phase_d = ~phase_q;
        end else begin
            count_d = count_q - PERIOD_W'(1);
        end
    end

    // Counter and phase state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= PERIOD_W'(PERIOD_RESET);
            phase_q <= 1'b0;
        end else begin
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/esn7e_demo_led_ctrl.sv
// Avalon-MM LED output port: DATA with atomic set/clear, registered LED
// drive, and an optional blink engine enabled by ESN7E_LED_BLINK_EN.
// Without the macro the port is plain registered DATA; addresses 1, 4
// and 5 then read 0 and ignore writes.
module esn7e_demo_led_ctrl
    import esn7e_demo_led_pkg::*;
#(
    parameter int unsigned      WIDTH        = 8,
    parameter int unsigned      PERIOD_W     = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter int unsigned      PERIOD_RESET = DEF_PERIOD_RESET
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic             wr_en;
    logic [WIDTH-1:0] wfield;
    logic             unused_wdata;

    assign wr_en        = chipselect && !write_n;
    assign wfield       = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] out_port_q, out_port_d;

    // DATA update: plain write, OR-set or AND-clear
    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:     data_d = wfield;
                ADDR_OUTSET:   data_d = data_q | wfield;
                ADDR_OUTCLEAR: data_d = data_q & ~wfield;
                default:       ;
            endcase
        end
    end

`ifdef ESN7E_LED_BLINK_EN
    logic [WIDTH-1:0]    mask_q, mask_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                restart, run, phase;

    // Blink configuration writes; restart on PERIOD write or mask leaving 0
    always_comb begin
        mask_d   = mask_q;
        period_d = period_q;
        if (wr_en && address == ADDR_BLINK_MASK) mask_d   = wfield;
        if (wr_en && address == ADDR_PERIOD)     period_d = writedata[PERIOD_W-1:0];
        restart  = (wr_en && address == ADDR_PERIOD) || (mask_q == '0 && mask_d != '0);
        run      = (mask_d != '0);
    end

    // Blink configuration registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q   <= '0;
            period_q <= PERIOD_W'(PERIOD_RESET);
        end else begin
            mask_q   <= mask_d;
            period_q <= period_d;
        end
    end

    // Timer sees the post-write period so a restart loads the new value
    esn7e_demo_led_blink_timer #(
        .PERIOD_W    (PERIOD_W),
        .PERIOD_RESET(PERIOD_RESET)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .run    (run),
        .restart(restart),
        .period (period_d),
        .phase  (phase)
    );

    // Phase 1 is the off half for masked bits
    always_comb begin
        out_port_d = data_q & ~(mask_q & {WIDTH{phase}});
    end
`else
    // No blink engine: LED drive is DATA delayed one cycle
    always_comb begin
        out_port_d = data_q;
    end
`endif

    // DATA and LED output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q     <= RESET_VALUE;
            out_port_q <= RESET_VALUE;
        end else begin
            data_q     <= data_d;
            out_port_q <= out_port_d;
        end
    end

    assign out_port = out_port_q;

    // Zero-wait read mux, zero-extended
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:       readdata[WIDTH-1:0] = data_q;
`ifdef ESN7E_LED_BLINK_EN
            ADDR_BLINK_MASK: readdata[WIDTH-1:0] = mask_q;
            ADDR_PERIOD:     readdata[PERIOD_W-1:0] = period_q;
            ADDR_STATUS: begin
                readdata[STATUS_PHASE_BIT] = phase;
                readdata[STATUS_RUN_BIT]   = (mask_q != '0);
            end
`endif
            default:         ;
        endcase
    end

endmodule

// File: tb/tb_esn7e_demo_led_ctrl.sv
// Self-checking bench for esn7e_demo_led_ctrl (WIDTH=8, RESET_VALUE=A5).
// Covers both builds via ESN7E_LED_BLINK_EN.
module tb_esn7e_demo_led_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect, write_n;
    logic [31:0] writedata, readdata;
    logic [7:0]  out_port;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    esn7e_demo_led_ctrl #(
        .WIDTH(8), .PERIOD_W(24), .RESET_VALUE(8'hA5), .PERIOD_RESET(2499999)
    ) dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
    );

    // Reference model: phase derived from cycles elapsed since last restart
    logic [7:0]  m_data, m_mask, m_out;
    logic [23:0] m_period;
    logic        m_phase;
    longint      m_elapsed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return {24'b0, m_data};
`ifdef ESN7E_LED_BLINK_EN
            3'd1: return {24'b0, m_mask};
            3'd4: return {8'b0, m_period};
            3'd5: return {30'b0, (m_mask != 8'h00), m_phase};
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_data = 8'hA5; m_mask = 8'h00; m_period = 24'd2499999;
        m_phase = 1'b0; m_elapsed = 0; m_out = 8'hA5;
    endtask

    task automatic model_edge(input logic [2:0] a, input bit wr, input logic [31:0] wd);
        logic [7:0] old_mask;
        bit         restart;
        old_mask = m_mask;
        restart  = 1'b0;
`ifdef ESN7E_LED_BLINK_EN
        m_out = m_data & ~(m_mask & {8{m_phase}});
`else
        m_out = m_data;
`endif
        if (wr) begin
            case (a)
                3'd0: m_data = wd[7:0];
                3'd2: m_data = m_data | wd[7:0];
                3'd3: m_data = m_data & ~wd[7:0];
`ifdef ESN7E_LED_BLINK_EN
                3'd1: m_mask = wd[7:0];
                3'd4: begin m_period = wd[23:0]; restart = 1'b1; end
`endif
                default: ;
            endcase
        end
`ifdef ESN7E_LED_BLINK_EN
        if (old_mask == 8'h00 && m_mask != 8'h00) restart = 1'b1;
        if (m_mask == 8'h00 || restart) begin
            m_elapsed = 0;
            m_phase   = 1'b0;
        end else begin
            m_elapsed++;
            m_phase = ((m_elapsed / (longint'(m_period) + 1)) % 2) == 1;
        end
`endif
    endtask

    // One bus cycle: drive, check at negedge, advance model at posedge
    task automatic step(input logic [2:0] a, input bit cs, input bit wn, input logic [31:0] wd,
                        input longint exp_rd = -1, input longint exp_out = -1);
        address = a; chipselect = cs; write_n = wn; writedata = wd;
        @(negedge clk);
        check("readdata_model", readdata, m_read(a));
        check("out_port_model", {24'b0, out_port}, {24'b0, m_out});
        if (exp_rd >= 0)  check("readdata_vec", readdata, exp_rd[31:0]);
        if (exp_out >= 0) check("out_port_vec", {24'b0, out_port}, exp_out[31:0]);
        @(posedge clk);
        model_edge(a, cs && !wn, wd);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd,
                      input longint exp_rd = -1, input longint exp_out = -1);
        step(a, 1'b1, 1'b0, wd, exp_rd, exp_out);
    endtask

    task automatic rd(input logic [2:0] a, input longint exp_rd = -1, input longint exp_out = -1);
        step(a, 1'b1, 1'b1, 32'h0, exp_rd, exp_out);
    endtask

    // Asynchronous reset in the middle of a cycle
    task automatic do_reset();
        #2;
        reset = 1'b1;
        chipselect = 1'b0; write_n = 1'b1;
        #1;
        check("reset_async_out", {24'b0, out_port}, 32'hA5);
        model_reset();
        @(negedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        model_edge(3'd0, 1'b0, 32'h0);
        #1;
    endtask

    typedef struct {
        logic [2:0]  a;
        bit          w;
        logic [31:0] d;
        longint      er;
        longint      eo;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bit   found;
        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        model_reset();
        #12;
        check("reset_out", {24'b0, out_port}, 32'hA5);
        #10 reset = 1'b0;
        @(posedge clk);
        model_edge(3'd0, 1'b0, 32'h0);
        #1;

        // Reset register contents
        rd(3'd0, 32'hA5, 32'hA5);
`ifdef ESN7E_LED_BLINK_EN
        rd(3'd4, 32'd2499999, -1);
`else
        rd(3'd4, 32'd0, -1);
`endif
        rd(3'd5, 32'd0, -1);

        // Set/clear vectors
        v = '{3'd0, 1'b1, 32'h0000_000F, -1, -1};   tbl.push_back(v);
        v = '{3'd2, 1'b1, 32'hFFFF_FFF0, -1, -1};   tbl.push_back(v);
        v = '{3'd3, 1'b1, 32'h0000_003C, -1, -1};   tbl.push_back(v);
        v = '{3'd0, 1'b0, 32'h0, 32'hC3, -1};       tbl.push_back(v);
        v = '{3'd2, 1'b0, 32'h0, 32'h0, 32'hC3};    tbl.push_back(v);
        v = '{3'd3, 1'b0, 32'h0, 32'h0, 32'hC3};    tbl.push_back(v);
        v = '{3'd6, 1'b1, 32'hFF, 32'h0, 32'hC3};   tbl.push_back(v);
        v = '{3'd7, 1'b0, 32'h0, 32'h0, 32'hC3};    tbl.push_back(v);
        v = '{3'd0, 1'b0, 32'h0, 32'hC3, 32'hC3};   tbl.push_back(v);
`ifndef ESN7E_LED_BLINK_EN
        v = '{3'd1, 1'b1, 32'hFF, 32'h0, 32'hC3};   tbl.push_back(v);
        v = '{3'd1, 1'b0, 32'h0, 32'h0, 32'hC3};    tbl.push_back(v);
        v = '{3'd4, 1'b1, 32'h5, 32'h0, 32'hC3};    tbl.push_back(v);
        v = '{3'd4, 1'b0, 32'h0, 32'h0, 32'hC3};    tbl.push_back(v);
        v = '{3'd5, 1'b0, 32'h0, 32'h0, 32'hC3};    tbl.push_back(v);
`endif
        foreach (tbl[i]) step(tbl[i].a, 1'b1, !tbl[i].w, tbl[i].d, tbl[i].er, tbl[i].eo);

`ifdef ESN7E_LED_BLINK_EN
        // Blink: PERIOD=3 -> 4-cycle halves, masked nibble goes dark
        wr(3'd4, 32'd3);
        wr(3'd0, 32'hFF);
        wr(3'd1, 32'h0F);
        for (int k = 1; k <= 16; k++) begin
            rd(3'd5, {30'b0, 1'b1, 1'(((k - 1) / 4) % 2)},
               (k >= 2 && ((k - 2) / 4) % 2 == 1) ? 32'hF0 : 32'hFF);
        end

        // Restart on terminal count during the off half
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            if (m_phase && (m_elapsed % (longint'(m_period) + 1)) == longint'(m_period)) found = 1'b1;
            else rd(3'd5);
        end
        check("restart_window_found", {31'b0, found}, 32'd1);
        wr(3'd4, 32'd9);
        for (int k = 1; k <= 11; k++) rd(3'd5, (k == 11) ? 32'd3 : 32'd2, -1);

        // Stop during the off half
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            if (m_phase) found = 1'b1;
            else rd(3'd5);
        end
        check("stop_window_found", {31'b0, found}, 32'd1);
        wr(3'd1, 32'h0);
        rd(3'd5, 32'd0, -1);
        rd(3'd5, 32'd0, 32'hFF);
        rd(3'd5, 32'd0, 32'hFF);

        // Get running again so the reset below lands mid-count
        wr(3'd4, 32'd2);
        wr(3'd1, 32'hF0);
        for (int k = 0; k < 5; k++) rd(3'd5);
`endif

        do_reset();
        rd(3'd0, 32'hA5, 32'hA5);
`ifdef ESN7E_LED_BLINK_EN
        rd(3'd4, 32'd2499999, 32'hA5);
        rd(3'd1, 32'd0, 32'hA5);
`else
        rd(3'd4, 32'd0, 32'hA5);
`endif
        rd(3'd5, 32'd0, 32'hA5);

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            logic [2:0]  a;
            logic [31:0] d;
            bit          cs, wn;
            a  = 3'($urandom_range(0, 7));
            cs = ($urandom_range(0, 3) != 0);
            wn = ($urandom_range(0, 1) != 0);
            d  = $urandom;
            if (a == 3'd4) d = $urandom_range(0, 6);
            if (a == 3'd1 && $urandom_range(0, 3) == 0) d = 32'h0;
            step(a, cs, wn, d);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
